// File: rtl/bsn_ctrl.sv
// Pipeline controller for the 8-input bitonic sorting network: slot tracking, backpressure, drain-then-turn direction changes.
// Optional BSN_CTRL_PERF_EN adds perf_sorted / perf_stall counters.
module bsn_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 8,
  parameter int PIPE_DEPTH = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0]     s_data,
  input  logic                               s_dir,
  output logic [N_INPUTS*DATA_WIDTH-1:0]     bsn_data_in,
  output logic                               bsn_en,
  output logic                               bsn_dir,
  input  logic [N_INPUTS*DATA_WIDTH-1:0]     bsn_data_out,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [N_INPUTS*DATA_WIDTH-1:0]     m_data,
  output logic                               m_dir,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]    occupancy
`ifdef BSN_CTRL_PERF_EN
  ,
  output logic [31:0]                        perf_sorted,
  output logic [31:0]                        perf_stall
`endif
);

  localparam int OW = $clog2(PIPE_DEPTH+1);

  typedef enum logic [1:0] {RUN, DRAIN, TURN} st_t;

  st_t                   st_q, st_d;
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [PIPE_DEPTH-1:0] dirq_q, dirq_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  cur_dir_q, cur_dir_d;
  logic                  adv, acc, deq;

  assign adv         = ~vld_q[PIPE_DEPTH-1] | m_ready;
  assign s_ready     = (st_q == RUN) & adv & (s_dir == cur_dir_q);
  assign acc         = s_valid & s_ready;
  assign deq         = vld_q[PIPE_DEPTH-1] & m_ready;
  assign occ_d       = occ_q + OW'(acc) - OW'(deq);

  assign bsn_data_in = s_data;
  assign bsn_en      = adv;
  assign bsn_dir     = cur_dir_q;
  assign m_data      = bsn_data_out;
  assign m_valid     = vld_q[PIPE_DEPTH-1];
  assign m_dir       = dirq_q[PIPE_DEPTH-1];
  assign occupancy   = occ_q;

  always_comb begin
    vld_d  = vld_q;
    dirq_d = dirq_q;
    if (adv) begin
      vld_d  = {vld_q[PIPE_DEPTH-2:0], acc};
      dirq_d = {dirq_q[PIPE_DEPTH-2:0], cur_dir_q};
    end
  end

  always_comb begin
    st_d      = st_q;
    cur_dir_d = cur_dir_q;
    unique case (st_q)
      RUN: begin
        if (s_valid && (s_dir != cur_dir_q)) begin
          if (occ_d != '0) begin
            st_d = DRAIN;
          end else begin
            st_d      = TURN;
            cur_dir_d = s_dir;
          end
        end
      end
      DRAIN: begin
        // Direction is one bit, so the pending request is always the inverse;
        // flipping keeps the turn intact even if the source drops s_valid.
        if (occ_d == '0) begin
          st_d      = TURN;
          cur_dir_d = ~cur_dir_q;
        end
      end
      TURN:    st_d = RUN;
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= RUN;
      vld_q     <= '0;
      dirq_q    <= '0;
      occ_q     <= '0;
      cur_dir_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      vld_q     <= vld_d;
      dirq_q    <= dirq_d;
      occ_q     <= occ_d;
      cur_dir_q <= cur_dir_d;
    end
  end

`ifdef BSN_CTRL_PERF_EN
  logic [31:0] perf_sorted_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_sorted_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (deq) perf_sorted_q <= perf_sorted_q + 32'd1;
      if (m_valid && !m_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_sorted = perf_sorted_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_bsn_ctrl.sv
// Bench for bsn_ctrl: behavioural sorting-network stand-in, transaction-level reference model,
// a directed vector table, hand-written corner sequences and randomized traffic.
module tb_bsn_ctrl;

  localparam int DW = 32;
  localparam int NI = 8;
  localparam int PD = 6;
  localparam int VW = DW*NI;

  logic          clk, rst;
  logic          s_valid, s_ready, s_dir;
  logic [VW-1:0] s_data, bsn_data_in, bsn_data_out, m_data;
  logic          bsn_en, bsn_dir, m_valid, m_ready, m_dir;
  logic [2:0]    occupancy;
`ifdef BSN_CTRL_PERF_EN
  logic [31:0]   perf_sorted, perf_stall;
`endif

  bsn_ctrl #(.DATA_WIDTH(DW), .N_INPUTS(NI), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dir(s_dir),
    .bsn_data_in(bsn_data_in), .bsn_en(bsn_en), .bsn_dir(bsn_dir),
    .bsn_data_out(bsn_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dir(m_dir),
    .occupancy(occupancy)
`ifdef BSN_CTRL_PERF_EN
    , .perf_sorted(perf_sorted), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // direction 0 = ascending (element 0 smallest), 1 = descending
  function automatic logic [VW-1:0] sortv(input logic [VW-1:0] v, input bit d);
    logic [DW-1:0] a [NI];
    logic [DW-1:0] t;
    logic [VW-1:0] r;
    for (int i = 0; i < NI; i++) a[i] = v[i*DW +: DW];
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NI-1-i; j++)
        if (d ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  // Stand-in network: sorts whatever it captures, then delays PD enabled cycles.
  logic [VW-1:0] net_q [PD];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PD; i++) net_q[i] <= '0;
    end else if (bsn_en) begin
      net_q[0] <= sortv(bsn_data_in, bsn_dir);
      for (int i = 1; i < PD; i++) net_q[i] <= net_q[i-1];
    end
  end
  assign bsn_data_out = net_q[PD-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight vectors with their slot position; mode 0=run,1=drain,2=turn
  typedef struct {int pos; logic [VW-1:0] v; bit d;} item_t;
  item_t mq[$];
  int    mode;
  bit    mcur;
  int    exp_sorted, exp_stall;

  bit            obs_rdy, obs_en, obs_mv;
  int            obs_occ;
  logic [VW-1:0] obs_md;

  task automatic model_reset();
    mq.delete();
    mode = 0; mcur = 1'b0; exp_sorted = 0; exp_stall = 0;
  endtask

  task automatic cycle(input bit sv, input bit sd, input logic [VW-1:0] sdat, input bit mr);
    bit head, adv, rdy;
    int n;
    s_valid = sv; s_dir = sd; s_data = sdat; m_ready = mr;
    @(negedge clk);
    head = (mq.size() > 0) && (mq[0].pos == PD-1);
    adv  = !head || mr;
    rdy  = (mode == 0) && adv && (sd == mcur);
    chk("s_ready", s_ready, rdy);
    chk("bsn_en", bsn_en, adv);
    chk("bsn_dir", bsn_dir, mcur);
    chk("m_valid", m_valid, head);
    chk("occupancy", occupancy, mq.size());
    chk("bsn_data_in", bsn_data_in, sdat);
    if (head) begin
      chk("m_data", m_data, mq[0].v);
      chk("m_dir", m_dir, mq[0].d);
    end
    obs_rdy = s_ready; obs_en = bsn_en; obs_mv = m_valid;
    obs_occ = int'(occupancy); obs_md = m_data;
    @(posedge clk);
    if (head && mr)  begin void'(mq.pop_front()); exp_sorted++; end
    if (head && !mr) exp_stall++;
    if (adv) foreach (mq[i]) mq[i].pos = mq[i].pos + 1;
    if (rdy && sv) mq.push_back('{0, sortv(sdat, mcur), mcur});
    n = mq.size();
    case (mode)
      0: if (sv && sd != mcur) begin
           if (n > 0) mode = 1;
           else begin mode = 2; mcur = sd; end
         end
      1: if (n == 0) begin mode = 2; mcur = !mcur; end
      default: mode = 0;
    endcase
    #1;
  endtask

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    s_valid = 1'b0; s_dir = 1'b0; m_ready = 1'b0; s_data = '0;
    rst = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  typedef struct {bit sv; bit sd; bit mr; bit rdy; bit en; bit mv; bit bdir; int occ;} row_t;
  row_t tbl [11];

  initial begin
    logic [VW-1:0] vin, vasc, held;
    int first_mv, mv_cnt, max_occ, low_cnt, lat;
    bit accepted;
    bit rdir;

    tbl[0]  = '{1,1,1, 0,1,0,0, 0};  // mismatch on empty pipe
    tbl[1]  = '{1,1,1, 0,1,0,1, 0};  // TURN, new direction visible
    tbl[2]  = '{1,1,1, 1,1,0,1, 0};  // accept
    tbl[3]  = '{0,1,0, 1,1,0,1, 1};
    tbl[4]  = '{0,1,0, 1,1,0,1, 1};
    tbl[5]  = '{0,1,0, 1,1,0,1, 1};
    tbl[6]  = '{0,1,0, 1,1,0,1, 1};
    tbl[7]  = '{0,1,0, 1,1,0,1, 1};
    tbl[8]  = '{0,1,0, 0,0,1,1, 1};  // output waiting, downstream stalls
    tbl[9]  = '{0,1,1, 1,1,1,1, 1};  // handshake
    tbl[10] = '{0,1,1, 1,1,0,1, 0};

    rst = 1'b0; s_valid = 1'b0; s_dir = 1'b0; m_ready = 1'b0; s_data = '0;
    #2;
    chk("rst s_ready", s_ready, 1);
    chk("rst bsn_en", bsn_en, 1);
    chk("rst bsn_dir", bsn_dir, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_dir", m_dir, 0);
    chk("rst occupancy", occupancy, 0);
    do_reset();

    // Directed table: empty-pipe direction switch and single-vector backpressure
    foreach (tbl[i]) begin
      cycle(tbl[i].sv, tbl[i].sd, rvec(), tbl[i].mr);
      chk($sformatf("tbl%0d s_ready", i), obs_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d bsn_en", i), obs_en, tbl[i].en);
      chk($sformatf("tbl%0d m_valid", i), obs_mv, tbl[i].mv);
      chk($sformatf("tbl%0d occupancy", i), obs_occ, tbl[i].occ);
    end

    // Six back-to-back vectors: latency, throughput, ascending result
    do_reset();
    vin = '0; vasc = '0;
    vin[0*DW +: DW] = 7; vin[1*DW +: DW] = 3; vin[2*DW +: DW] = 0; vin[3*DW +: DW] = 5;
    vin[4*DW +: DW] = 1; vin[5*DW +: DW] = 6; vin[6*DW +: DW] = 2; vin[7*DW +: DW] = 4;
    for (int i = 0; i < NI; i++) vasc[i*DW +: DW] = i;
    first_mv = -1; mv_cnt = 0; max_occ = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(i < 6, 1'b0, (i == 0) ? vin : rvec(), 1'b1);
      if (obs_occ > max_occ) max_occ = obs_occ;
      if (obs_mv) begin
        mv_cnt++;
        if (first_mv < 0) begin
          first_mv = i;
          chk("first sorted vector", obs_md, vasc);
        end
      end
    end
    chk("first m_valid cycle", first_mv, 6);
    chk("output count", mv_cnt, 6);
    chk("peak occupancy", max_occ, 6);

    // Full pipe under backpressure, then simultaneous accept and handshake
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, rvec(), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, rvec(), 1'b0);
      if (i == 0) held = obs_md;
      chk("bp bsn_en", obs_en, 0);
      chk("bp s_ready", obs_rdy, 0);
      chk("bp occupancy", obs_occ, 6);
      chk("bp m_data stable", obs_md, held);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, rvec(), 1'b1);
      chk("full-rate occupancy", obs_occ, 6);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, rvec(), 1'b1);

    // Direction change with 3 in flight: drain time plus one TURN cycle
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rvec(), 1'b1);
    low_cnt = 0; accepted = 1'b0;
    for (int i = 0; i < 30 && !accepted; i++) begin
      cycle(1'b1, 1'b1, rvec(), 1'b1);
      if (obs_rdy) accepted = 1'b1; else low_cnt++;
    end
    chk("drain turn accepted", accepted, 1);
    chk("drain turn stall cycles", low_cnt, 7);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, rvec(), 1'b1);
    chk("bsn_dir after turn", bsn_dir, 1);

    // Asynchronous reset mid-stream with occupancy 4
    do_reset();
    cycle(1'b1, 1'b1, rvec(), 1'b0);
    cycle(1'b1, 1'b1, rvec(), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, rvec(), 1'b0);
    chk("pre-reset occupancy", occupancy, 4);
    s_valid = 1'b0; s_dir = 1'b0; m_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async rst s_ready", s_ready, 1);
    chk("async rst bsn_en", bsn_en, 1);
    chk("async rst bsn_dir", bsn_dir, 0);
    chk("async rst m_valid", m_valid, 0);
    chk("async rst occupancy", occupancy, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, rvec(), 1'b1);
    cycle(1'b1, 1'b0, rvec(), 1'b1);
    lat = -1;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      cycle(1'b0, 1'b0, rvec(), 1'b1);
      if (obs_mv) lat = i;
    end
    chk("post-reset latency", lat, 6);

`ifdef BSN_CTRL_PERF_EN
    do_reset();
    for (int i = 0; i < 26; i++) cycle(i < 10, 1'b0, rvec(), !(i >= 12 && i < 15));
    chk("perf_sorted", perf_sorted, 10);
    chk("perf_stall", perf_stall, 3);
`endif

    // Randomized traffic against the reference model
    do_reset();
    rdir = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15, 0) == 0) rdir = !rdir;
      cycle($urandom_range(3, 0) != 0, rdir, rvec(), $urandom_range(3, 0) != 0);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, rdir, rvec(), 1'b1);
    chk("random final occupancy", occupancy, 0);
`ifdef BSN_CTRL_PERF_EN
    chk("random perf_sorted", perf_sorted, exp_sorted);
    chk("random perf_stall", perf_stall, exp_stall);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsn_ctrl.md
# bsn_ctrl

Pipeline controller for the 8-input, 6-stage bitonic sorting network in the sorter building block. It sits between an upstream valid/ready vector source and a downstream valid/ready sink. It drives the network's shared `en` and `direction` inputs and tracks which pipeline slots hold real vectors. Because the network has a single global direction, the controller drains in-flight vectors before honouring a direction change.

## Interface
- `DATA_WIDTH`, 32: bits per element.
- `N_INPUTS`, 8: elements per vector.
- `PIPE_DEPTH`, 6: register stages in the network between data in and data out.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset. It is shared with the sorting network.
- `s_valid` input 1: upstream vector valid.
- `s_ready` output 1: upstream ready.
- `s_data` input N_INPUTS*DATA_WIDTH: unsorted vector.
- `s_dir` input 1: requested sort direction for `s_data` (same encoding as the network's `direction`).
- `bsn_data_in` output N_INPUTS*DATA_WIDTH: to the network's `data_in`. This is a combinational pass-through of `s_data`.
- `bsn_en` output 1: to the network's `en`.
- `bsn_dir` output 1: to the network's `direction`. Driven from register `cur_dir`.
- `bsn_data_out` input N_INPUTS*DATA_WIDTH: from the network's `data_out`.
- `m_valid` output 1: sorted vector valid.
- `m_ready` input 1: downstream ready.
- `m_data` output N_INPUTS*DATA_WIDTH: equals `bsn_data_out`.
- `m_dir` output 1: direction used for `m_data`.
- `occupancy` output $clog2(PIPE_DEPTH+1): number of valid vectors in flight.

## Operation
- `adv = !vld[PIPE_DEPTH-1] | m_ready`, and `bsn_en = adv`. The entire network either advances or freezes.
- `vld[PIPE_DEPTH-1:0]` is a slot-valid shift register that shifts only when `adv` is high. `vld[0]` loads the accept flag `acc = s_valid & s_ready`. A bubble (0) enters when nothing is accepted.
- `dirq[PIPE_DEPTH-1:0]` is a parallel shift of `cur_dir`. It is used for `m_dir = dirq[PIPE_DEPTH-1]`.
- `m_valid = vld[PIPE_DEPTH-1]`.
- `occupancy` increments on `acc`, decrements on `m_valid & m_ready`, and holds when both occur. Range is 0..PIPE_DEPTH.
- State machine `st` has three states: RUN, DRAIN, TURN.
  - RUN: `s_ready = adv & (s_dir == cur_dir)`.
    - If `s_valid & s_dir != cur_dir` and the next occupancy is nonzero, go to DRAIN.
    - If `s_valid & s_dir != cur_dir` and occupancy is zero, go to TURN and load `cur_dir <= s_dir`.
  - DRAIN: `s_ready = 0`; the pipe keeps advancing and bubbles are inserted. When occupancy reaches 0, go to TURN and load `cur_dir <= s_dir`.
  - TURN: `s_ready = 0` for one cycle, then go to RUN. This gives the network one settled cycle with the new direction before the next capture.
- A direction mismatch is evaluated only while `s_valid` is high. A source that withdraws `s_valid` in DRAIN does not cancel the drain; the turn still completes.
- Reset (asserted at any time, including mid-stream) clears:
  - `vld` and `dirq` to 0
  - `occupancy` to 0
  - `cur_dir` to 0
  - `st` to RUN

  In-flight vectors are lost, with no partial output.

## Timing
- Reset values of outputs: `s_ready` = 1 (RUN, dir 0, empty), `bsn_en` = 1, `bsn_dir` = 0, `m_valid` = 0, `m_dir` = 0, `occupancy` = 0. `m_data` and `bsn_data_in` follow their inputs.
- Latency with `m_ready` held high:
  - A vector accepted on the edge ending cycle t has `m_valid` = 1 in cycle t+PIPE_DEPTH (t+6).
  - Throughput is 1 vector per cycle.
- Backpressure: while `m_valid & !m_ready`, `bsn_en` = 0 and `s_ready` = 0. The network and all controller state hold. `m_data` is stable until the handshake.
- Full pipe (occupancy 6) with `m_ready` = 1: input acceptance and output handshake happen on the same edge, and occupancy stays 6.
- Direction-change penalty when the pipe is empty: 2 cycles, one for the RUN→TURN mismatch cycle and one for TURN. With k vectors in flight, the penalty is the drain time plus 1 cycle.

## Configuration
- `BSN_CTRL_PERF_EN` defined: adds 32-bit outputs `perf_sorted` and `perf_stall`.
  - `perf_sorted` increments on each `m_valid & m_ready`.
  - `perf_stall` increments on each cycle with `m_valid & !m_ready`.
  - Both counters reset to 0 on `rst` and wrap at 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then 6 back-to-back vectors with dir 0 and `m_ready` = 1: `m_valid` rises exactly 6 cycles after the first accept; 6 consecutive outputs, each ascending (e.g. {7,3,0,5,1,6,2,4} → {0..7}); `occupancy` peaks at 6.
- `m_ready` = 0 for 4 cycles while the pipe is full: `bsn_en` = 0, `s_ready` = 0, `m_data` stable, `occupancy` held at 6. Resume with no loss or duplicate.
- 3 vectors with dir 0, then a dir 1 request: DRAIN until `occupancy` = 0, 1 TURN cycle, then `bsn_dir` = 1; `m_dir` = 0 for the first 3 outputs and 1 afterwards (descending).
- Direction switch on an empty pipe: `s_ready` is low for exactly 2 cycles, then the vector is accepted.
- Reset asserted asynchronously mid-stream with occupancy 4: all outputs return to reset values immediately; no `m_valid` after release until a new accept plus 6 cycles.
- With `BSN_CTRL_PERF_EN`: 10 outputs with 3 stall cycles → `perf_sorted` = 10, `perf_stall` = 3.
